bus_master_8088: RTL and testbench

//  8088-style bus initiator: turns single-byte transfer requests from a local

---
 rtl/bus_master_8088.sv | 168 ++++++++++++++++
 tb/tb_bus_master_8088.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_8088.sv
// 8088-style bus initiator: converts single-byte client requests into
// T1-T2-T3-(Tw)-T4 cycles on the multiplexed bus and reports completion.
module bus_master_8088 #(
    parameter int unsigned ADDR_W   = 20,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_io,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_err,
    output logic              ALE,
    output logic              RD,
    output logic              WR,
    output logic              IOM,
    output logic [ADDR_W-9:0] A,
    inout  logic [7:0]        AD,
    input  logic              READY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_T3,
        S_TW,
        S_T4
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic              io_q, io_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic              abort_q, abort_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              ale_q, ale_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              ad_oe_q, ad_oe_d;
    logic [7:0]        ad_out_q, ad_out_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              strobe_phase;

    assign req_ready = (state_q == S_IDLE) || (state_q == S_T4);

    // IOM and A are only reloaded on acceptance, which always enters T1, so
    // the captured request fields already hold them stable through T4 and beyond.
    assign IOM       = io_q;
    assign A         = addr_q[ADDR_W-1:8];
    assign ALE       = ale_q;
    assign RD        = rd_q;
    assign WR        = wr_q;
    assign AD        = ad_oe_q ? ad_out_q : 'z;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rdata_q;

    // Next-state, request capture, wait counting and read-data capture.
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        io_d    = io_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wcnt_d  = wcnt_q;
        abort_d = abort_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE, S_T4: begin
                if (req_valid) begin
                    state_d = S_T1;
                    write_d = req_write;
                    io_d    = req_io;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wcnt_d  = '0;
                    abort_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_T1: state_d = S_T2;
            S_T2: state_d = S_T3;
            S_T3: begin
                if (READY) begin
                    state_d = S_T4;
                    if (!write_q) rdata_d = AD;
                end else begin
                    state_d = S_TW;
                    wcnt_d  = 8'd1;
                end
            end
            S_TW: begin
                if (READY) begin
                    state_d = S_T4;
                    if (!write_q) rdata_d = AD;
                end else if (wcnt_q == WAIT_LIMIT) begin
                    state_d = S_T4;
                    abort_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs are registered, so they are derived from the state being entered.
    always_comb begin
        strobe_phase = (state_d == S_T2) || (state_d == S_T3) || (state_d == S_TW);
        ale_d        = (state_d == S_T1);
        rd_d         = !(strobe_phase && !write_d);
        wr_d         = !(strobe_phase && write_d);
        ad_oe_d      = (state_d == S_T1) || (write_d && (strobe_phase || state_d == S_T4));
        ad_out_d     = (state_d == S_T1) ? addr_d[7:0] : wdata_d;
        rsp_valid_d  = (state_d == S_T4);
        rsp_err_d    = (state_d == S_T4) && abort_d;
    end

    // State and output registers; reset drops strobes and AD drive immediately.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            write_q     <= 1'b0;
            io_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wcnt_q      <= '0;
            abort_q     <= 1'b0;
            rdata_q     <= '0;
            ale_q       <= 1'b0;
            rd_q        <= 1'b1;
            wr_q        <= 1'b1;
            ad_oe_q     <= 1'b0;
            ad_out_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            io_q        <= io_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wcnt_q      <= wcnt_d;
            abort_q     <= abort_d;
            rdata_q     <= rdata_d;
            ale_q       <= ale_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            ad_oe_q     <= ad_oe_d;
            ad_out_q    <= ad_out_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_bus_master_8088.sv
// Directed bench for bus_master_8088 with a small memory/IO responder model.
module tb_bus_master_8088;

    logic        CLK;
    logic        RESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_io;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        ALE;
    logic        RD;
    logic        WR;
    logic        IOM;
    logic [11:0] A;
    tri1  [7:0]  AD;
    logic        READY;

    int total = 0;
    int bad   = 0;

    // Responder model: latches {IOM, AD} on ALE, stores on WR low, drives
    // read data from the cycle after RD falls (so read T2 must float high).
    logic [7:0] mem [0:511];
    logic [8:0] lat_idx;
    logic       rd_seen;
    logic       ovr_en;
    logic [7:0] ovr_val;

    assign AD = (!RD && rd_seen) ? (ovr_en ? ovr_val : mem[lat_idx]) : 'z;

    always @(negedge CLK) begin
        if (ALE) lat_idx = {IOM, AD};
        if (!WR) mem[lat_idx] = AD;
    end

    always @(posedge CLK) rd_seen <= !RD;

    bus_master_8088 #(.ADDR_W(20), .MAX_WAIT(15)) dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ALE(ALE), .RD(RD), .WR(WR), .IOM(IOM), .A(A), .AD(AD), .READY(READY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Runs one request; READY is held low for n_wait samples in T3/Tw.
    task automatic run_cycle(
        input  logic w, input logic io, input logic [19:0] addr, input logic [7:0] wd,
        input  int n_wait, input logic late, input logic [7:0] late_val,
        output int lat, output int rd_lo, output int wr_lo, output int ale_hi,
        output int adz, output int adw, output logic [11:0] t1_a, output logic [7:0] t1_ad,
        output logic t1_iom, output logic [7:0] rdat, output logic err,
        output logic extra, output logic [7:0] ad_after);
        int  scnt;
        logic done;
        lat = -1; rd_lo = 0; wr_lo = 0; ale_hi = 0; adz = 0; adw = 0; scnt = 0;
        rdat = '0; err = 1'b0; done = 1'b0; t1_a = '0; t1_ad = '0; t1_iom = 1'b0;
        req_write = w; req_io = io; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        READY = (n_wait == 0);
        tick;
        req_valid = 1'b0; req_write = ~w; req_io = ~io; req_addr = ~addr; req_wdata = ~wd;
        for (int i = 1; i <= 60 && !done; i++) begin
            if (i == 1) begin t1_a = A; t1_ad = AD; t1_iom = IOM; end
            if (!RD) rd_lo++;
            if (!WR) wr_lo++;
            if (ALE) ale_hi++;
            if (!RD && AD === 8'hFF) adz++;
            if (i > 1 && AD === wd) adw++;
            if (!RD || !WR) scnt++;
            READY = (scnt >= 2 + n_wait);
            if (READY && late) ovr_val = late_val;
            if (rsp_valid) begin
                done = 1'b1; lat = i; rdat = rsp_rdata; err = rsp_err;
            end else begin
                tick;
            end
        end
        tick;
        extra = rsp_valid;
        ad_after = AD;
        READY = 1'b1;
    endtask

    task automatic test_reset;
        tick; tick;
        total++; if (ALE !== 1'b0) begin bad++; $display("FAIL rst_ale: got %b want 0", ALE); end
        total++; if (RD !== 1'b1 || WR !== 1'b1) begin bad++; $display("FAIL rst_strobes: got RD=%b WR=%b want 1/1", RD, WR); end
        total++; if (IOM !== 1'b0 || A !== 12'h000) begin bad++; $display("FAIL rst_addr: got IOM=%b A=%h want 0/000", IOM, A); end
        total++; if (AD !== 8'hFF) begin bad++; $display("FAIL rst_ad_float: got %h want FF", AD); end
        total++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 8'h00) begin
            bad++; $display("FAIL rst_rsp: got v=%b e=%b d=%h want 0/0/00", rsp_valid, rsp_err, rsp_rdata); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", req_ready); end
        RESET = 1'b1;
        tick;
    endtask

    task automatic test_mem_read;
        int lat, rl, wl, ah, az, aw; logic [11:0] ta; logic [7:0] tad, rd, aa; logic tio, er, ex;
        ovr_en = 1'b1; ovr_val = 8'h3C;
        run_cycle(1'b0, 1'b0, 20'hA5123, 8'h00, 0, 1'b0, 8'h00,
                  lat, rl, wl, ah, az, aw, ta, tad, tio, rd, er, ex, aa);
        total++; if (lat !== 4) begin bad++; $display("FAIL rd_latency: got %0d want 4", lat); end
        total++; if (ah !== 1 || ta !== 12'hA51 || tad !== 8'h23 || tio !== 1'b0) begin
            bad++; $display("FAIL rd_t1: got ale=%0d A=%h AD=%h IOM=%b want 1/A51/23/0", ah, ta, tad, tio); end
        total++; if (rl !== 2 || wl !== 0) begin bad++; $display("FAIL rd_strobe: got rd=%0d wr=%0d want 2/0", rl, wl); end
        total++; if (az !== 1) begin bad++; $display("FAIL rd_t2_float: got %0d want 1", az); end
        total++; if (rd !== 8'h3C || er !== 1'b0) begin bad++; $display("FAIL rd_data: got %h err=%b want 3C/0", rd, er); end
        total++; if (ex !== 1'b0) begin bad++; $display("FAIL rd_pulse: got %b want 0", ex); end
    endtask

    task automatic test_io_write;
        int lat, rl, wl, ah, az, aw; logic [11:0] ta; logic [7:0] tad, rd, aa; logic tio, er, ex;
        ovr_en = 1'b0;
        run_cycle(1'b1, 1'b1, 20'h00080, 8'h5A, 0, 1'b0, 8'h00,
                  lat, rl, wl, ah, az, aw, ta, tad, tio, rd, er, ex, aa);
        total++; if (lat !== 4 || er !== 1'b0) begin bad++; $display("FAIL wr_latency: got %0d err=%b want 4/0", lat, er); end
        total++; if (tio !== 1'b1 || ta !== 12'h000 || tad !== 8'h80) begin
            bad++; $display("FAIL wr_t1: got IOM=%b A=%h AD=%h want 1/000/80", tio, ta, tad); end
        total++; if (wl !== 2 || rl !== 0) begin bad++; $display("FAIL wr_strobe: got wr=%0d rd=%0d want 2/0", wl, rl); end
        total++; if (aw !== 3) begin bad++; $display("FAIL wr_ad_drive: got %0d want 3", aw); end
        total++; if (aa !== 8'hFF) begin bad++; $display("FAIL wr_ad_release: got %h want FF", aa); end
        total++; if (mem[9'h180] !== 8'h5A) begin bad++; $display("FAIL wr_target: got %h want 5A", mem[9'h180]); end
        total++; if (rd !== 8'h3C) begin bad++; $display("FAIL wr_rdata_hold: got %h want 3C", rd); end
    endtask

    task automatic test_wait_states;
        int lat, rl, wl, ah, az, aw; logic [11:0] ta; logic [7:0] tad, rd, aa; logic tio, er, ex;
        ovr_en = 1'b1; ovr_val = 8'h11;
        run_cycle(1'b0, 1'b0, 20'h12345, 8'h00, 3, 1'b1, 8'h77,
                  lat, rl, wl, ah, az, aw, ta, tad, tio, rd, er, ex, aa);
        total++; if (lat !== 7) begin bad++; $display("FAIL wait_latency: got %0d want 7", lat); end
        total++; if (rl !== 5) begin bad++; $display("FAIL wait_rd_low: got %0d want 5", rl); end
        total++; if (rd !== 8'h77 || er !== 1'b0) begin bad++; $display("FAIL wait_data: got %h err=%b want 77/0", rd, er); end
    endtask

    task automatic test_timeout;
        int lat, rl, wl, ah, az, aw; logic [11:0] ta; logic [7:0] tad, rd, aa; logic tio, er, ex;
        ovr_en = 1'b1; ovr_val = 8'h99;
        run_cycle(1'b0, 1'b0, 20'h00042, 8'h00, 100, 1'b0, 8'h00,
                  lat, rl, wl, ah, az, aw, ta, tad, tio, rd, er, ex, aa);
        total++; if (lat !== 19) begin bad++; $display("FAIL to_latency: got %0d want 19", lat); end
        total++; if (rl !== 17) begin bad++; $display("FAIL to_rd_low: got %0d want 17", rl); end
        total++; if (er !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", er); end
        total++; if (rd !== 8'h77) begin bad++; $display("FAIL to_rdata_hold: got %h want 77", rd); end
        total++; if (RD !== 1'b1 || WR !== 1'b1 || ex !== 1'b0) begin
            bad++; $display("FAIL to_release: got RD=%b WR=%b v=%b want 1/1/0", RD, WR, ex); end
        ovr_en = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic seen;
        req_write = 1'b1; req_io = 1'b0; req_addr = 20'h01234; req_wdata = 8'hC3; req_valid = 1'b1;
        READY = 1'b1;
        tick;
        req_write = 1'b0; req_wdata = 8'h00;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (rsp_valid) seen = 1'b1;
            else tick;
        end
        total++; if (!seen || req_ready !== 1'b1) begin bad++; $display("FAIL b2b_wr_done: got seen=%b ready=%b want 1/1", seen, req_ready); end
        tick;
        req_valid = 1'b0;
        total++; if (ALE !== 1'b1 || A !== 12'h012 || AD !== 8'h34 || WR !== 1'b1) begin
            bad++; $display("FAIL b2b_t1: got ALE=%b A=%h AD=%h WR=%b want 1/012/34/1", ALE, A, AD, WR); end
        tick;
        total++; if (RD !== 1'b0 || AD !== 8'hFF) begin bad++; $display("FAIL b2b_t2_float: got RD=%b AD=%h want 0/FF", RD, AD); end
        tick; tick;
        total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hC3) begin
            bad++; $display("FAIL b2b_rdata: got v=%b d=%h want 1/C3", rsp_valid, rsp_rdata); end
        tick;
    endtask

    task automatic test_reset_mid_cycle;
        int lat, rl, wl, ah, az, aw; logic [11:0] ta; logic [7:0] tad, rd, aa; logic tio, er, ex;
        logic pulse;
        req_write = 1'b1; req_io = 1'b0; req_addr = 20'h00055; req_wdata = 8'hAA; req_valid = 1'b1;
        READY = 1'b0;
        tick;
        req_valid = 1'b0;
        tick; tick; tick; tick;
        total++; if (WR !== 1'b0 || AD !== 8'hAA) begin bad++; $display("FAIL mr_in_tw: got WR=%b AD=%h want 0/AA", WR, AD); end
        #2 RESET = 1'b0;
        #1;
        total++; if (WR !== 1'b1 || RD !== 1'b1 || ALE !== 1'b0 || AD !== 8'hFF) begin
            bad++; $display("FAIL mr_release: got WR=%b RD=%b ALE=%b AD=%h want 1/1/0/FF", WR, RD, ALE, AD); end
        pulse = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (rsp_valid !== 1'b0) pulse = 1'b1;
        end
        RESET = 1'b1;
        READY = 1'b1;
        tick;
        if (rsp_valid !== 1'b0) pulse = 1'b1;
        total++; if (pulse !== 1'b0) begin bad++; $display("FAIL mr_no_rsp: got %b want 0", pulse); end
        run_cycle(1'b0, 1'b1, 20'h00080, 8'h00, 0, 1'b0, 8'h00,
                  lat, rl, wl, ah, az, aw, ta, tad, tio, rd, er, ex, aa);
        total++; if (lat !== 4 || rd !== 8'h5A || er !== 1'b0) begin
            bad++; $display("FAIL mr_recover: got lat=%0d d=%h err=%b want 4/5A/0", lat, rd, er); end
    endtask

    initial begin
        RESET = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_io = 1'b0;
        req_addr = '0; req_wdata = '0; READY = 1'b1; ovr_en = 1'b0; ovr_val = '0;
        lat_idx = '0;
        test_reset;
        test_mem_read;
        test_io_write;
        test_wait_states;
        test_timeout;
        test_back_to_back;
        test_reset_mid_cycle;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
